tim_ic_filter: RTL and testbench

Input-capture front end for one timer channel, sitting directly upstream of the capture/compare unit of `apoip_timer`. It synchronises the asynchronous channel pin (e.g. `timx_ch1_in`), applies a configurable sampling digital filter and selects the edge polarity. It then prescales the selected edges into a single-cycle capture event that the capture unit consumes. One instance is used per channel (CH1–CH4).

---
 rtl/tim_ic_pkg.sv | 45 ++++
 rtl/tim_ic_sync_filt.sv | 76 +++++++
 rtl/tim_ic_filter.sv | 94 +++++++++
 tb/tb_tim_ic_filter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tim_ic_pkg.sv
// tim_ic_pkg
// Shared definitions for the timer input-capture front end.
//   - edge_sel_t : which filtered edge(s) feed the capture prescaler
//   - ICF_*      : bit positions of the two fields inside cfg_icf
//   - icf_div    : sampling divider value (1/2/4/8) from cfg_icf[3:2]
//   - icf_n      : filter sample count N (2/4/8/16) from cfg_icf[1:0]
//   - psc_div    : capture prescaler ratio (1/2/4/8) from cfg_icpsc
//   - edge_decode: {ccnp,ccp} polarity bits to edge_sel_t
package tim_ic_pkg;

  localparam int FCNT_W_DEF = 4;

  localparam int ICF_DIV_MSB = 3;
  localparam int ICF_DIV_LSB = 2;
  localparam int ICF_N_MSB   = 1;
  localparam int ICF_N_LSB   = 0;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_sel_t;

  function automatic logic [3:0] icf_div(input logic [1:0] sel);
    return 4'd1 << sel;
  endfunction

  function automatic logic [4:0] icf_n(input logic [1:0] sel);
    return 5'd2 << sel;
  endfunction

  function automatic logic [3:0] psc_div(input logic [1:0] sel);
    return 4'd1 << sel;
  endfunction

  // {ccnp,ccp} = 10 is a reserved combination and falls back to rising.
  function automatic edge_sel_t edge_decode(input logic ccnp, input logic ccp);
    case ({ccnp, ccp})
      2'b01:   return EDGE_FALL;
      2'b11:   return EDGE_BOTH;
      default: return EDGE_RISE;
    endcase
  endfunction

endpackage

// File: rtl/tim_ic_sync_filt.sv
// tim_ic_sync_filt
// Synchroniser, sampling divider and digital filter for one capture pin.
// Ports:
//   clk, rst  : kernel clock, synchronous active-high reset
//   ch_in     : asynchronous channel pin
//   cfg_icf   : filter setting ([3:2] divider exponent, [1:0] N select, 0 = bypass)
//   cfg_clr   : clears divider and filter counter, holds the filtered level
//   ti_filt   : registered filtered level
module tim_ic_sync_filt
  import tim_ic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FCNT_W      = FCNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_in,
  input  logic [3:0] cfg_icf,
  input  logic       cfg_clr,
  output logic       ti_filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [2:0]             div_cnt;
  logic [2:0]             div_lim;
  logic                   tick;
  logic [FCNT_W-1:0]      fcnt;
  logic [FCNT_W-1:0]      n_lim;
  logic                   bypass;

  // Pin enters at bit 0 and leaves at the top bit; depth must be at least 2.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ch_in};
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign bypass  = (cfg_icf == 4'd0);
  assign div_lim = 3'(icf_div(cfg_icf[ICF_DIV_MSB:ICF_DIV_LSB]) - 4'd1);
  assign n_lim   = FCNT_W'(icf_n(cfg_icf[ICF_N_MSB:ICF_N_LSB]) - 5'd1);

  // With div=1 the tick is forced high so a stale count cannot gate sampling.
  assign tick = (div_lim == 3'd0) || (div_cnt == div_lim);

  // Divider wraps only on an exact match; a count left above a newly lowered
  // limit keeps counting through the 3-bit rollover and meets it again.
  always_ff @(posedge clk) begin
    if (rst || cfg_clr)          div_cnt <= 3'd0;
    else if (div_cnt == div_lim) div_cnt <= 3'd0;
    else                         div_cnt <= div_cnt + 3'd1;
  end

  // Filter: level moves only after N consecutive differing samples on ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      ti_filt <= 1'b0;
      fcnt    <= '0;
    end else if (cfg_clr) begin
      fcnt    <= '0;
    end else if (bypass) begin
      ti_filt <= s;
      fcnt    <= '0;
    end else if (tick) begin
      if (s == ti_filt) begin
        fcnt <= '0;
      end else if (fcnt == n_lim) begin
        ti_filt <= s;
        fcnt    <= '0;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tim_ic_filter.sv
// tim_ic_filter
// Input-capture front end for one timer channel: synchronise and filter the
// pin, detect edges, select polarity and prescale into a capture event.
// Ports:
//   apb_clk, apb_rst   : kernel clock, synchronous active-high reset
//   ch_in              : asynchronous channel pin
//   cfg_icf            : filter setting (0 = bypass)
//   cfg_ccp, cfg_ccnp  : edge polarity {ccnp,ccp}: 00/10 rise, 01 fall, 11 both
//   cfg_cce            : capture enable
//   cfg_icpsc          : event every 1/2/4/8 selected edges
//   cfg_clr            : one-cycle clear of divider, filter count and prescaler
//   ti_filt            : filtered level
//   ti_rise, ti_fall   : single-cycle edge pulses of ti_filt
//   ic_evt             : registered single-cycle capture event
module tim_ic_filter
  import tim_ic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FCNT_W      = FCNT_W_DEF
) (
  input  logic       apb_clk,
  input  logic       apb_rst,
  input  logic       ch_in,
  input  logic [3:0] cfg_icf,
  input  logic       cfg_ccp,
  input  logic       cfg_ccnp,
  input  logic       cfg_cce,
  input  logic [1:0] cfg_icpsc,
  input  logic       cfg_clr,
  output logic       ti_filt,
  output logic       ti_rise,
  output logic       ti_fall,
  output logic       ic_evt
);

  logic      filt_d;
  logic      sel;
  logic [2:0] pcnt;
  logic [2:0] psc_lim;
  edge_sel_t edge_sel;

  tim_ic_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FCNT_W      (FCNT_W)
  ) u_sync_filt (
    .clk     (apb_clk),
    .rst     (apb_rst),
    .ch_in   (ch_in),
    .cfg_icf (cfg_icf),
    .cfg_clr (cfg_clr),
    .ti_filt (ti_filt)
  );

  // Delayed copy for edge detection; a clear leaves it untouched so an edge
  // already in flight is still reported on ti_rise/ti_fall.
  always_ff @(posedge apb_clk) begin
    if (apb_rst) filt_d <= 1'b0;
    else         filt_d <= ti_filt;
  end

  assign ti_rise  = ti_filt & ~filt_d;
  assign ti_fall  = ~ti_filt & filt_d;
  assign edge_sel = edge_decode(cfg_ccnp, cfg_ccp);
  assign psc_lim  = 3'(psc_div(cfg_icpsc) - 4'd1);

  always_comb begin
    sel = 1'b0;
    case (edge_sel)
      EDGE_FALL: sel = ti_fall;
      EDGE_BOTH: sel = ti_rise | ti_fall;
      default:   sel = ti_rise;
    endcase
  end

  // Prescaler: exact-match wrap so a lowered ratio rolls over instead of
  // locking; disabled capture parks the count at zero.
  always_ff @(posedge apb_clk) begin
    if (apb_rst || cfg_clr || !cfg_cce) begin
      pcnt   <= 3'd0;
      ic_evt <= 1'b0;
    end else begin
      ic_evt <= 1'b0;
      if (sel) begin
        if (pcnt == psc_lim) begin
          ic_evt <= 1'b1;
          pcnt   <= 3'd0;
        end else begin
          pcnt <= pcnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tim_ic_filter.sv
// tb_tim_ic_filter
// Directed bench for tim_ic_filter. Expected capture-event cycles are queued
// when an edge is driven and popped by a monitor whenever ic_evt fires.
module tb_tim_ic_filter;

  logic       apb_clk;
  logic       apb_rst;
  logic       ch_in;
  logic [3:0] cfg_icf;
  logic       cfg_ccp;
  logic       cfg_ccnp;
  logic       cfg_cce;
  logic [1:0] cfg_icpsc;
  logic       cfg_clr;
  logic       ti_filt;
  logic       ti_rise;
  logic       ti_fall;
  logic       ic_evt;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int exp_q[$];
  int e_cyc;
  int e, k, c, r;

  tim_ic_filter #(
    .SYNC_STAGES (2),
    .FCNT_W      (4)
  ) dut (
    .apb_clk   (apb_clk),
    .apb_rst   (apb_rst),
    .ch_in     (ch_in),
    .cfg_icf   (cfg_icf),
    .cfg_ccp   (cfg_ccp),
    .cfg_ccnp  (cfg_ccnp),
    .cfg_cce   (cfg_cce),
    .cfg_icpsc (cfg_icpsc),
    .cfg_clr   (cfg_clr),
    .ti_filt   (ti_filt),
    .ti_rise   (ti_rise),
    .ti_fall   (ti_fall),
    .ic_evt    (ic_evt)
  );

  // Free-running clock and an edge counter used as the timing reference.
  initial begin
    apb_clk = 1'b0;
    forever #5 apb_clk = ~apb_clk;
  end

  always @(posedge apb_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v);
    ch_in = v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge apb_clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge apb_clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every ic_evt must match the oldest queued cycle.
  always @(negedge apb_clk) begin
    if (ic_evt === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL ic_evt_unexpected observed_cycle=%0d expected=none", cyc);
      end else begin
        e_cyc = exp_q.pop_front();
        check_output("ic_evt_cycle", cyc, e_cyc);
      end
    end
  end

  initial begin
    ch_in     = 1'b0;
    apb_rst   = 1'b1;
    cfg_icf   = 4'd0;
    cfg_ccp   = 1'b0;
    cfg_ccnp  = 1'b0;
    cfg_cce   = 1'b1;
    cfg_icpsc = 2'd0;
    cfg_clr   = 1'b0;
    step(3);
    check_output("rst_filt", ti_filt, 0);
    check_output("rst_rise", ti_rise, 0);
    check_output("rst_fall", ti_fall, 0);
    check_output("rst_evt",  ic_evt,  0);
    apb_rst = 1'b0;
    step(3);

    // Bypass, rising edge
    $display("[TB] bypass rising");
    e = cyc; apply_stimulus(1'b1); k = e + 1;
    exp_q.push_back(k + 3);
    wait_until(k + 1); check_output("byp_filt_early", ti_filt, 0);
    wait_until(k + 2); check_output("byp_filt", ti_filt, 1);
    check_output("byp_rise", ti_rise, 1);
    wait_until(k + 3); check_output("byp_rise_end", ti_rise, 0);
    check_output("byp_evt", ic_evt, 1);
    step(3);
    apply_stimulus(1'b0); k = cyc + 1;
    wait_until(k + 2); check_output("byp_fall", ti_fall, 1);
    step(4);

    // Glitch rejection, div1 N=8
    $display("[TB] glitch rejection");
    cfg_icf = 4'b0010;
    step(2);
    apply_stimulus(1'b1); step(5);
    apply_stimulus(1'b0); step(4);
    apply_stimulus(1'b1); step(3);
    apply_stimulus(1'b0); step(4);
    check_output("glitch_hold", ti_filt, 0);
    e = cyc; apply_stimulus(1'b1); k = e + 1;
    exp_q.push_back(k + 10);
    wait_until(k + 8); check_output("filt_n8_early", ti_filt, 0);
    wait_until(k + 9); check_output("filt_n8", ti_filt, 1);
    check_output("filt_n8_rise", ti_rise, 1);
    apply_stimulus(1'b0);
    step(12);
    check_output("filt_n8_fall", ti_filt, 0);

    // Divided sampling, div2 N=2, ticks aligned by a clear
    $display("[TB] divided sampling");
    cfg_icf = 4'b0100;
    cfg_clr = 1'b1; step(1); cfg_clr = 1'b0;
    c = cyc; apply_stimulus(1'b1); step(3); apply_stimulus(1'b0);
    wait_until(c + 10); check_output("div2_reject", ti_filt, 0);
    cfg_clr = 1'b1; step(1); cfg_clr = 1'b0;
    c = cyc; apply_stimulus(1'b1);
    exp_q.push_back(c + 7);
    step(5); apply_stimulus(1'b0);
    check_output("div2_early", ti_filt, 0);
    wait_until(c + 6); check_output("div2_pass", ti_filt, 1);
    wait_until(c + 14); check_output("div2_fall", ti_filt, 0);

    // Both edges, prescale by 4
    $display("[TB] both edges psc4");
    cfg_icf   = 4'd0;
    cfg_ccp   = 1'b1;
    cfg_ccnp  = 1'b1;
    cfg_icpsc = 2'd2;
    cfg_clr = 1'b1; step(1); cfg_clr = 1'b0;
    step(2);
    for (int i = 1; i <= 8; i++) begin
      e = cyc; apply_stimulus(~ch_in);
      if (i % 4 == 0) exp_q.push_back(e + 4);
      step(3);
    end
    step(6);

    // Clear colliding with the fourth selected edge
    $display("[TB] clear collision");
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(~ch_in);
      step(4);
    end
    e = cyc; apply_stimulus(~ch_in);
    wait_until(e + 3);
    cfg_clr = 1'b1; step(1); cfg_clr = 1'b0;
    check_output("clr_evt", ic_evt, 0);
    check_output("clr_keeps_filt", ti_filt, ch_in);
    step(3);
    for (int i = 1; i <= 4; i++) begin
      e = cyc; apply_stimulus(~ch_in);
      if (i == 4) exp_q.push_back(e + 4);
      step(4);
    end
    step(4);

    // Capture disabled, then reset mid-filter
    $display("[TB] disable and reset");
    cfg_ccp   = 1'b0;
    cfg_ccnp  = 1'b0;
    cfg_icpsc = 2'd0;
    cfg_cce   = 1'b0;
    step(2);
    e = cyc; apply_stimulus(1'b1); k = e + 1;
    wait_until(k + 2); check_output("dis_rise", ti_rise, 1);
    wait_until(k + 3); check_output("dis_evt", ic_evt, 0);
    apply_stimulus(1'b0);
    step(6);
    cfg_cce = 1'b1;
    cfg_icf = 4'b0011;
    step(1);
    e = cyc; apply_stimulus(1'b1); k = e + 1;
    wait_until(k + 8); check_output("mid_filter", ti_filt, 0);
    apb_rst = 1'b1;
    cfg_icf = 4'd0;
    step(1);
    check_output("mid_rst_filt", ti_filt, 0);
    check_output("mid_rst_rise", ti_rise, 0);
    check_output("mid_rst_fall", ti_fall, 0);
    check_output("mid_rst_evt",  ic_evt,  0);
    step(2);
    r = cyc; apb_rst = 1'b0; k = r + 1;
    exp_q.push_back(k + 3);
    wait_until(k + 1); check_output("post_rst_early", ti_filt, 0);
    wait_until(k + 2); check_output("post_rst_filt", ti_filt, 1);
    check_output("post_rst_rise", ti_rise, 1);
    step(8);
    check_output("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
